// File: rtl/memshare_pkg.sv
// Shared defaults, FSM state encoding and width helper for the column-bank drain slice.
package memshare_pkg;

    localparam int unsigned GROUP_SIZE_DEF = 4;
    localparam int unsigned ADDR_W_DEF     = 3;
    localparam int unsigned DATA_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Requestor ID width; a single-requestor group still carries a 1-bit ID.
    function automatic int unsigned calc_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memshare_lat_pipe.sv
// READ_LAT-deep {valid,id} shift register tracking bank reads until their data returns.
module memshare_lat_pipe #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ID_W     = 2
) (
    input  logic            sys_clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [READ_LAT-1:0] vld_q;
    logic [ID_W-1:0]     id_q [READ_LAT];

    // Idle slots carry a zero ID so resp_id rests at 0 between responses.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int s = 0; s < int'(READ_LAT); s++) begin
                id_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_valid ? in_id : '0;
            for (int s = 1; s < int'(READ_LAT); s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[READ_LAT-1];
    assign out_id    = id_q[READ_LAT-1];

endmodule

// File: rtl/memshare_bank_drain.sv
// Snapshots pending requests of a sharing group and drains them one per cycle
// into the shared column-bank read port, tagging returned words with requestor ID.
module memshare_bank_drain
    import memshare_pkg::*;
#(
    parameter int unsigned GROUP_SIZE = GROUP_SIZE_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ID_W       = calc_id_w(GROUP_SIZE),
    parameter int unsigned READ_LAT   = 1,
    localparam int unsigned CNT_W     = $clog2(GROUP_SIZE + 1)
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         load,
    input  logic [GROUP_SIZE-1:0]        rqst_valid,
    input  logic [GROUP_SIZE*ADDR_W-1:0] rqst_addr,
    input  logic                         bank_ready,
    output logic                         bank_ren,
    output logic [ADDR_W-1:0]            bank_raddr,
    input  logic [DATA_W-1:0]            bank_rdata,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [DATA_W-1:0]            resp_data,
    output logic [CNT_W-1:0]             pend_cnt,
    output logic                         busy,
    output logic                         done
);

    state_t            state;
    logic [ID_W-1:0]   q_id   [GROUP_SIZE];
    logic [ADDR_W-1:0] q_addr [GROUP_SIZE];
    logic [CNT_W-1:0]  inflight;

    logic [ID_W-1:0]   cap_id   [GROUP_SIZE];
    logic [ADDR_W-1:0] cap_addr [GROUP_SIZE];
    logic [CNT_W-1:0]  cap_cnt;
    logic              issue;

    // Compaction: each valid requestor lands in the slot given by the count of valid requestors below it.
    always_comb begin
        int pos;
        pos = 0;
        for (int j = 0; j < int'(GROUP_SIZE); j++) begin
            cap_id[j]   = '0;
            cap_addr[j] = '0;
        end
        for (int k = 0; k < int'(GROUP_SIZE); k++) begin
            if (rqst_valid[k]) begin
                for (int j = 0; j < int'(GROUP_SIZE); j++) begin
                    if (pos == j) begin
                        cap_id[j]   = ID_W'(k);
                        cap_addr[j] = rqst_addr[k*ADDR_W +: ADDR_W];
                    end
                end
                pos = pos + 1;
            end
        end
        cap_cnt = CNT_W'(pos);
    end

    assign bank_ren   = (state == DRAIN) && (pend_cnt != '0);
    assign bank_raddr = q_addr[0];
    assign issue      = bank_ren && bank_ready;
    assign busy       = (state != IDLE);
    assign resp_data  = bank_rdata;
    // Last response (or an empty snapshot) ends the flush.
    assign done       = (state == FLUSH) &&
                        ((inflight == '0) || ((inflight == CNT_W'(1)) && resp_valid));

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state    <= IDLE;
            pend_cnt <= '0;
            inflight <= '0;
            for (int j = 0; j < int'(GROUP_SIZE); j++) begin
                q_id[j]   <= '0;
                q_addr[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        q_id     <= cap_id;
                        q_addr   <= cap_addr;
                        pend_cnt <= cap_cnt;
                        state    <= (cap_cnt != '0) ? DRAIN : FLUSH;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        for (int j = 0; j < int'(GROUP_SIZE) - 1; j++) begin
                            q_id[j]   <= q_id[j+1];
                            q_addr[j] <= q_addr[j+1];
                        end
                        q_id[GROUP_SIZE-1]   <= '0;
                        q_addr[GROUP_SIZE-1] <= '0;
                        pend_cnt             <= pend_cnt - CNT_W'(1);
                        if (pend_cnt == CNT_W'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Reads issued but whose data has not yet been returned.
            case ({issue, resp_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    memshare_lat_pipe #(
        .READ_LAT (READ_LAT),
        .ID_W     (ID_W)
    ) u_lat_pipe (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (issue),
        .in_id     (q_id[0]),
        .out_valid (resp_valid),
        .out_id    (resp_id)
    );

endmodule

// File: tb/tb_memshare_bank_drain.sv
// Bench for memshare_bank_drain: two instances (READ_LAT 1 and 3) share stimulus;
// a timeline model checks control outputs and a per-instance monitor scores responses.
module tb_memshare_bank_drain;

    localparam int G   = 4;
    localparam int AW  = 3;
    localparam int DW  = 8;
    localparam int IW  = 2;
    localparam int CW  = 3;
    localparam int AVW = G * AW;

    typedef struct {
        int id;
        int addr;
    } ent_t;

    logic           sys_clk;
    logic           rstn;
    logic           load;
    logic [G-1:0]   rqst_valid;
    logic [AVW-1:0] rqst_addr;
    logic           bank_ready;

    logic           bank_ren   [2];
    logic [AW-1:0]  bank_raddr [2];
    logic [DW-1:0]  bank_rdata [2];
    logic           resp_valid [2];
    logic [IW-1:0]  resp_id    [2];
    logic [DW-1:0]  resp_data  [2];
    logic [CW-1:0]  pend_cnt   [2];
    logic           busy       [2];
    logic           done       [2];

    logic [DW-1:0]  mem [8];
    ent_t           entries [$];
    int             load_gen = 0;
    int             total = 0;
    int             bad = 0;
    int             rl_of [2] = '{1, 3};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RL = (gi == 0) ? 1 : 3;
        logic [RL-1:0] pv = '0;
        logic [AW-1:0] pa [RL];
        logic [DW-1:0] junk = '0;
        int            rsp_ptr = 0;
        int            seen_gen = 0;

        memshare_bank_drain #(
            .GROUP_SIZE (G),
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .READ_LAT   (RL)
        ) u_dut (
            .sys_clk    (sys_clk),
            .rstn       (rstn),
            .load       (load),
            .rqst_valid (rqst_valid),
            .rqst_addr  (rqst_addr),
            .bank_ready (bank_ready),
            .bank_ren   (bank_ren[gi]),
            .bank_raddr (bank_raddr[gi]),
            .bank_rdata (bank_rdata[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_id    (resp_id[gi]),
            .resp_data  (resp_data[gi]),
            .pend_cnt   (pend_cnt[gi]),
            .busy       (busy[gi]),
            .done       (done[gi])
        );

        // Bank model: data for a read accepted in cycle c is presented in cycle c+RL; garbage otherwise.
        always @(posedge sys_clk) begin
            for (int s = RL - 1; s > 0; s--) begin
                pv[s] <= pv[s-1];
                pa[s] <= pa[s-1];
            end
            pv[0] <= bank_ren[gi] && bank_ready;
            pa[0] <= bank_raddr[gi];
            junk  <= DW'($urandom);
        end
        assign bank_rdata[gi] = pv[RL-1] ? mem[pa[RL-1]] : junk;

        // Response monitor: pops the expected {id, data} in issue order.
        always @(negedge sys_clk) begin
            if (seen_gen != load_gen) begin
                seen_gen = load_gen;
                rsp_ptr  = 0;
            end
            if (rstn && resp_valid[gi]) begin
                if (rsp_ptr >= entries.size()) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    check("resp_id", int'(resp_id[gi]), entries[rsp_ptr].id);
                    check("resp_data", int'(resp_data[gi]), int'(mem[entries[rsp_ptr].addr]));
                    rsp_ptr++;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_bank_ren"},   int'(bank_ren[i]),   0);
            check({tag, "_bank_raddr"}, int'(bank_raddr[i]), 0);
            check({tag, "_resp_valid"}, int'(resp_valid[i]), 0);
            check({tag, "_resp_id"},    int'(resp_id[i]),    0);
            check({tag, "_busy"},       int'(busy[i]),       0);
            check({tag, "_done"},       int'(done[i]),       0);
            check({tag, "_pend_cnt"},   int'(pend_cnt[i]),   0);
        end
    endtask

    // One snapshot: expected timeline derived from issue count, stall cycles and read latency.
    task automatic run_load(input logic [G-1:0] v, input logic [AVW-1:0] a,
                            input logic [31:0] rpat, input bit use_pat);
        int n;
        int k;
        int last;
        int rel;
        bit past [2];
        bit de;
        entries.delete();
        for (int j = 0; j < G; j++) begin
            if (v[j]) entries.push_back('{id: j, addr: int'(a[j*AW +: AW])});
        end
        n = entries.size();
        k = 0;
        last = 0;
        rel = 0;
        past[0] = 1'b0;
        past[1] = 1'b0;
        @(posedge sys_clk); #1;
        load       = 1'b1;
        rqst_valid = v;
        rqst_addr  = a;
        load_gen++;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) check("idle_busy", int'(busy[i]), 0);
        while (!(past[0] && past[1])) begin
            rel++;
            if (rel > 200) begin
                check("drain_timeout", rel, 0);
                break;
            end
            @(posedge sys_clk); #1;
            bank_ready = use_pat ? ((rel < 32) ? rpat[rel] : 1'b1) : ($urandom_range(3) != 0);
            load = (k < n) && ($urandom_range(3) == 0);
            if (load) begin
                rqst_valid = G'($urandom);
                rqst_addr  = AVW'($urandom);
            end
            @(negedge sys_clk);
            for (int i = 0; i < 2; i++) begin
                de = (n == 0) ? (rel == 1) : ((k == n) && (rel == last + rl_of[i]));
                check("done", int'(done[i]), int'(de));
                check("busy", int'(busy[i]), int'(!past[i]));
                check("pend_cnt", int'(pend_cnt[i]), n - k);
                check("bank_ren", int'(bank_ren[i]), int'(k < n));
                if (k < n) check("bank_raddr", int'(bank_raddr[i]), entries[k].addr);
                if (de) past[i] = 1'b1;
            end
            if (k < n && bank_ready) begin
                k++;
                last = rel;
            end
        end
        @(posedge sys_clk); #1;
        load = 1'b0;
        bank_ready = $urandom_range(1) != 0;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            check("after_busy", int'(busy[i]), 0);
            check("after_done", int'(done[i]), 0);
            check("after_ren", int'(bank_ren[i]), 0);
        end
        check("resp_count_lat1", g_inst[0].rsp_ptr, n);
        check("resp_count_lat3", g_inst[1].rsp_ptr, n);
    endtask

    // Reset asserted in the cycle of the second issue; in-flight reads must be dropped.
    task automatic reset_mid_drain();
        entries.delete();
        @(posedge sys_clk); #1;
        load       = 1'b1;
        rqst_valid = '1;
        rqst_addr  = AVW'($urandom);
        bank_ready = 1'b1;
        for (int j = 0; j < G; j++) entries.push_back('{id: j, addr: int'(rqst_addr[j*AW +: AW])});
        load_gen++;
        @(posedge sys_clk); #1;
        load = 1'b0;
        @(posedge sys_clk); #1;
        rstn = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) check("rst_pend_before", int'(pend_cnt[i]), 3);
        @(posedge sys_clk); #1;
        rstn = 1'b1;
        entries.delete();
        load_gen++;
        repeat (4) begin
            @(negedge sys_clk);
            check_zero("post_rst");
            @(posedge sys_clk); #1;
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) mem[a] = DW'($urandom);
        rstn       = 1'b0;
        load       = 1'b0;
        rqst_valid = '0;
        rqst_addr  = '0;
        bank_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_zero("reset");
        @(posedge sys_clk); #1;
        rstn = 1'b1;

        run_load(4'b1111, {3'd1, 3'd7, 3'd2, 3'd5}, '1, 1'b1);
        run_load(4'b1010, {3'd6, 3'd0, 3'd3, 3'd0}, '1, 1'b1);
        run_load(4'b0111, AVW'($urandom), 32'hFFFF_FFF3, 1'b1);
        run_load(4'b0000, AVW'($urandom), '1, 1'b1);
        reset_mid_drain();
        run_load(4'b1111, AVW'($urandom), '1, 1'b0);
        for (int r = 0; r < 25; r++) begin
            run_load(G'($urandom), AVW'($urandom), '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memshare_bank_drain.md
# memshare_bank_drain

Consumer side of a column-bank sharing group: captures a snapshot of pending requests from up to GROUP_SIZE requestors, drains them one per cycle into the single shared column-bank read port, and returns each read word tagged with its requestor ID. It sits between the access-request generator's per-group pending storage and the column-bank memory. It replaces ad-hoc head-pop logic with an explicit drain FSM, bank back-pressure and in-flight tracking.

## Interface
- GROUP_SIZE, 4, requestors sharing one column bank (1..8)
- ADDR_W, 3, bank address width per request
- DATA_W, 8, bank read-data width
- ID_W, $clog2(GROUP_SIZE) (min 1), requestor ID width
- READ_LAT, 1, bank read latency in cycles (1..4)

Ports:
- sys_clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- load  in  1  capture strobe, honoured only in IDLE
- rqst_valid  in  GROUP_SIZE  bit k = requestor k has a pending request
- rqst_addr  in  GROUP_SIZE*ADDR_W  requestor k address at [k*ADDR_W +: ADDR_W]
- bank_ready  in  1  bank accepts a read this cycle
- bank_ren  out  1  bank read enable
- bank_raddr  out  ADDR_W  bank read address
- bank_rdata  in  DATA_W  valid READ_LAT cycles after a bank_ren&&bank_ready cycle
- resp_valid  out  1  response strobe
- resp_id  out  ID_W  requestor owning resp_data
- resp_data  out  DATA_W  read word (bank_rdata passthrough)
- pend_cnt  out  $clog2(GROUP_SIZE+1)  entries not yet issued
- busy  out  1  high in DRAIN and FLUSH
- done  out  1  one-cycle pulse at end of drain

## Operation
- FSM: IDLE, DRAIN, FLUSH.
- IDLE: on load, capture valid requestors into a compacted queue in ascending index order (entry = {id, addr}); pend_cnt <= popcount(rqst_valid); go to DRAIN if popcount>0, else FLUSH.
- DRAIN: bank_ren = (pend_cnt!=0); bank_raddr = head addr (combinational). Pop on bank_ren&&bank_ready: queue shifts one toward head, pend_cnt decrements, head id pushed into latency pipe. When the last entry pops, go to FLUSH.
- bank_ren may be high with bank_ready low; this is not an issue; entry held, no pop.
- FLUSH: wait until in-flight count is 0. done pulses in the cycle the last resp_valid is presented (or the first FLUSH cycle if nothing was issued); next state IDLE.
- Latency pipe: READ_LAT stages of {valid, id}. resp_valid/resp_id = pipe output; resp_data = bank_rdata unregistered.
- In-flight counter: +1 on issue, -1 on resp_valid, both same cycle = no change; max GROUP_SIZE.
- load outside IDLE is ignored; no capture, no error.
- Reset (any state): state IDLE, queue/pend_cnt/pipe cleared. bank_ren, resp_valid, busy, done, pend_cnt = 0; bank_raddr, resp_id = 0. Responses in flight at reset are discarded.

## Timing
- load at cycle t → busy high from t+1; first bank_ren at t+1.
- Issue at cycle c → resp_valid at c+READ_LAT.
- N requests with bank_ready always high: issues t+1..t+N, responses t+1+READ_LAT..t+N+READ_LAT, done at t+N+READ_LAT, busy low and load accepted from t+N+READ_LAT+1.
- Zero valid requests: busy and done high at t+1 only.
- Each bank_ready-low cycle in DRAIN delays all later events by one cycle.
- Throughput: one issue per cycle; back-to-back loads need a gap of one cycle after done.

## Structure
- Package memshare_pkg: default GROUP_SIZE/ADDR_W/DATA_W, the state enum (IDLE, DRAIN, FLUSH), and a helper function computing ID_W.
- Sub-module memshare_lat_pipe: parameterised READ_LAT-deep {valid,id} shift register with synchronous clear. All other logic stays in the top module. Compaction is a combinational prefix-count over rqst_valid.

## Test plan
- Reset mid-DRAIN: load 4 requests, assert rstn=0 at second issue → next cycle all outputs 0, no resp_valid even though bank_rdata toggles, next load works normally.
- Full group: rqst_valid=4'b1111, addrs 5,2,7,1, bank_ready=1, READ_LAT=1 → raddr 5,2,7,1 on t+1..t+4; resp_id 0,1,2,3 at t+2..t+5 with matching model data; done at t+5.
- Sparse/compaction: rqst_valid=4'b1010, addrs[1]=3, addrs[3]=6 → exactly two issues (3 then 6), resp_id 1 then 3, pend_cnt 2→1→0.
- Back-pressure: 3 requests, bank_ready low at t+2 and t+3 → raddr held stable while stalled, issues at t+1,t+4,t+5, done at t+6; resp order preserved.
- Empty load and ignored load: load with rqst_valid=0 → done and busy at t+1 only, bank_ren never high; load pulsed during DRAIN → pend_cnt and queue unchanged.
- READ_LAT=3, 2 requests → resp_valid at issue+3 each; in-flight count peaks at 2; done coincides with second response.
